int_issue_queue: RTL and testbench
==================================

INT_ISSUE_QUEUE -- requirements
Module: int_issue_queue

Interface
REQ-001 Parameter DEPTH, default 4: number of queue entries, 2..16.
REQ-002 Parameter TAG_W, default 6: width of rename tags.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_disp_valid  input  1  dispatch request for one instruction this cycle.
REQ-006 i_disp_data  input  int_fifo_data  opcode, func3, func7, rd_tag, wb_valid, rs1/rs2 data.
REQ-007 i_rs1_tag, i_rs2_tag  input  TAG_W each  producer tags for operands that are not ready.
REQ-008 i_rs1_rdy, i_rs2_rdy  input  1 each  operand data at dispatch is already valid.
REQ-009 i_cdb  input  cdb_bfm  common data bus broadcast; cdb_valid qualifies tag and result.
REQ-010 issue_granted  input  1  the arbiter accepts the current issue request this cycle.
REQ-011 o_issue_req  output  1  an entry with both operands ready exists.
REQ-012 int_exec_fifo_data  output  int_fifo_data  the oldest ready entry, valid while o_issue_req=1.
REQ-013 o_full  output  1  all DEPTH entries are occupied.
REQ-014 o_count  output  $clog2(DEPTH+1)  number of occupied entries.

Function
REQ-015 Entries SHALL be age-ordered in a shift-collapse array, with index 0 the oldest.
REQ-016 Each entry SHALL hold: valid, opcode/func3/func7, rd_tag, wb_valid, and per operand data, tag and rdy.
REQ-017 Dispatch SHALL write the first free slot when i_disp_valid=1 and o_full=0; dispatch while o_full=1 SHALL be dropped with no state change.
REQ-018 o_full and o_count SHALL be derived from registered state only; an issue in the same cycle does not make room for a dispatch.
REQ-019 CDB wakeup: each valid entry with operand rdy=0, i_cdb.cdb_valid=1 and a matching tag SHALL load cdb_result and set rdy on the next edge.
REQ-020 An operand being dispatched whose tag matches a valid CDB broadcast in the same cycle SHALL be written as ready with cdb_result.
REQ-021 One CDB broadcast MAY wake both operands of the same entry and operands in multiple entries simultaneously.
REQ-022 o_issue_req and int_exec_fifo_data SHALL be combinational from registered entries, selecting the lowest index with both operands ready.
REQ-023 int_exec_fifo_data SHALL be all-zero when o_issue_req=0.
REQ-024 On issue_granted=1 with o_issue_req=1, the selected entry SHALL be removed, and younger entries SHALL shift down one slot at the next edge.
REQ-025 issue_granted=1 with o_issue_req=0 SHALL be ignored.
REQ-026 A wakeup in cycle N SHALL make the entry issuable in cycle N+1 at the earliest; wakeup results are not forwarded to issue in the same cycle.
REQ-027 Issue, dispatch and wakeup in the same cycle SHALL all take effect; the new entry lands at index count-1 when an issue occurs, otherwise at index count.
REQ-028 o_count SHALL increment by 1 on dispatch only, decrement by 1 on issue only, and stay unchanged on both or neither.
REQ-029 Branch entries (BRANCH_TYPE) SHALL be queued and issued like any other opcode.

Reset
REQ-030 rst_n=0 SHALL asynchronously clear all entry valid bits, operand rdy bits and stored fields to 0.
REQ-031 During reset, o_issue_req=0, o_full=0, o_count=0 and int_exec_fifo_data=0.
REQ-032 Deasserting reset in the middle of traffic SHALL leave an empty queue; in-flight dispatch or grant inputs in that cycle are discarded.

Configuration
REQ-033 Macro INT_IQ_FLUSH_EN: when defined, i_cdb.cdb_branch=1 with cdb_branch_taken=1 SHALL clear all entries at the next edge.
REQ-034 When a flush occurs, it SHALL take priority over a dispatch, issue or wakeup in the same cycle.
REQ-035 Without INT_IQ_FLUSH_EN, branch broadcasts SHALL have no effect on the queue.

Verification
REQ-036 Dispatch ADD with rs1=5 and rs2=7 both ready, grant held at 1 -> o_issue_req=1 the next cycle with rs1_data=5, rs2_data=7, and o_count returns to 0 after the grant.
REQ-037 Dispatch an entry with rs1 waiting on tag 3, then broadcast cdb_valid=1, tag=3, result=0x10 -> rs1_data=0x10, and o_issue_req rises exactly one cycle after the broadcast.
REQ-038 Fill DEPTH=4 entries, then dispatch a fifth entry with grant=1 in the same cycle -> the fifth entry is dropped, o_count=3, and the remaining entries are in order.
REQ-039 Two entries: the older waits on tag 2, the younger is ready -> the younger issues first, and after tag 2 wakes up the older issues next.
REQ-040 Dispatch an entry waiting on tag 4 while a CDB broadcast of tag 4 (result 9) occurs in the same cycle -> the entry is stored ready with data 9.
REQ-041 With INT_IQ_FLUSH_EN defined, 3 entries plus a taken-branch broadcast together with a dispatch -> o_count=0 and o_issue_req=0 the next cycle.

Source files
------------

// File: rtl/int_iq_pkg.sv
// Shared types for the integer issue queue: dispatch payload, CDB broadcast and opcode constants.
package int_iq_pkg;

   localparam int unsigned CDB_TAG_W = 6;
   localparam logic [6:0] BRANCH_TYPE = 7'b1100011;
   localparam logic [6:0] OP_TYPE     = 7'b0110011;

   typedef struct packed {
      logic [6:0]           opcode;
      logic [2:0]           func3;
      logic [6:0]           func7;
      logic [CDB_TAG_W-1:0] rd_tag;
      logic                 wb_valid;
      logic [31:0]          rs1_data;
      logic [31:0]          rs2_data;
   } int_fifo_data;

   typedef struct packed {
      logic                 cdb_valid;
      logic [CDB_TAG_W-1:0] cdb_tag;
      logic [31:0]          cdb_result;
      logic                 cdb_branch;
      logic                 cdb_branch_taken;
   } cdb_bfm;

endpackage

// File: rtl/int_issue_queue.sv
// Age-ordered shift-collapse integer issue queue with CDB wakeup and oldest-ready issue.
// Optional macro INT_IQ_FLUSH_EN: a taken-branch CDB broadcast empties the queue.
module int_issue_queue
   import int_iq_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TAG_W = 6
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_disp_valid,
   input  int_fifo_data                 i_disp_data,
   input  logic [TAG_W-1:0]             i_rs1_tag,
   input  logic [TAG_W-1:0]             i_rs2_tag,
   input  logic                         i_rs1_rdy,
   input  logic                         i_rs2_rdy,
   input  cdb_bfm                       i_cdb,
   input  logic                         issue_granted,
   output logic                         o_issue_req,
   output int_fifo_data                 int_exec_fifo_data,
   output logic                         o_full,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);

   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   typedef struct packed {
      logic             valid;
      int_fifo_data     d;
      logic [TAG_W-1:0] rs1_tag;
      logic [TAG_W-1:0] rs2_tag;
      logic             rs1_rdy;
      logic             rs2_rdy;
   } entry_t;

   entry_t           ent_q [DEPTH];
   entry_t           ent_d [DEPTH];
   entry_t           woke  [DEPTH+1];
   entry_t           disp_ent;
   logic [CNT_W-1:0] count_q, count_d, disp_pos;
   logic [DEPTH-1:0] ready, sel_oh, shift;
   logic             issue, disp_ok, flush;
   logic [TAG_W-1:0] cdb_tag;

   assign cdb_tag = TAG_W'(i_cdb.cdb_tag);

`ifdef INT_IQ_FLUSH_EN
   assign flush = i_cdb.cdb_branch & i_cdb.cdb_branch_taken;
`else
   logic unused_branch;
   assign unused_branch = i_cdb.cdb_branch ^ i_cdb.cdb_branch_taken;
   assign flush = 1'b0;
`endif

   // Wakeup view of each stored entry; slot DEPTH is an empty filler for the shift.
   always_comb begin
      woke[DEPTH] = '0;
      for (int i = 0; i < DEPTH; i++) begin
         woke[i]  = ent_q[i];
         ready[i] = ent_q[i].valid & ent_q[i].rs1_rdy & ent_q[i].rs2_rdy;
         if (ent_q[i].valid && i_cdb.cdb_valid) begin
            if (!ent_q[i].rs1_rdy && ent_q[i].rs1_tag == cdb_tag) begin
               woke[i].rs1_rdy    = 1'b1;
               woke[i].d.rs1_data = i_cdb.cdb_result;
            end
            if (!ent_q[i].rs2_rdy && ent_q[i].rs2_tag == cdb_tag) begin
               woke[i].rs2_rdy    = 1'b1;
               woke[i].d.rs2_data = i_cdb.cdb_result;
            end
         end
      end
   end

   // Oldest ready entry; shift marks the selected slot and everything younger.
   always_comb begin
      logic found;
      found  = 1'b0;
      sel_oh = '0;
      shift  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         sel_oh[i] = ready[i] & ~found;
         found     = found | ready[i];
         shift[i]  = found;
      end
   end

   always_comb begin
      int_exec_fifo_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (sel_oh[i]) int_exec_fifo_data = ent_q[i].d;
      end
   end

   assign o_issue_req = |ready;
   assign o_full      = (count_q == CNT_W'(DEPTH));
   assign o_count     = count_q;
   assign issue       = issue_granted & o_issue_req;
   assign disp_ok     = i_disp_valid & ~o_full;
   assign disp_pos    = count_q - CNT_W'(issue);

   // A dispatched operand can be woken by the broadcast of the same cycle.
   always_comb begin
      disp_ent         = '0;
      disp_ent.valid   = 1'b1;
      disp_ent.d       = i_disp_data;
      disp_ent.rs1_tag = i_rs1_tag;
      disp_ent.rs2_tag = i_rs2_tag;
      disp_ent.rs1_rdy = i_rs1_rdy;
      disp_ent.rs2_rdy = i_rs2_rdy;
      if (i_cdb.cdb_valid) begin
         if (!i_rs1_rdy && i_rs1_tag == cdb_tag) begin
            disp_ent.rs1_rdy    = 1'b1;
            disp_ent.d.rs1_data = i_cdb.cdb_result;
         end
         if (!i_rs2_rdy && i_rs2_tag == cdb_tag) begin
            disp_ent.rs2_rdy    = 1'b1;
            disp_ent.d.rs2_data = i_cdb.cdb_result;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i] = (issue && shift[i]) ? woke[i+1] : woke[i];
         if (disp_ok && CNT_W'(i) == disp_pos) ent_d[i] = disp_ent;
         if (flush) ent_d[i] = '0;
      end
      case ({disp_ok, issue})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (flush) count_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      end else begin
         count_q <= count_d;
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      end
   end

endmodule

// File: tb/tb_int_issue_queue.sv
// Bench for int_issue_queue: directed scenarios plus random traffic against a queue-based model.
module tb_int_issue_queue;
   import int_iq_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TAG_W = 6;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               disp_valid;
   int_fifo_data       disp_data;
   logic [TAG_W-1:0]   rs1_tag, rs2_tag;
   logic               rs1_rdy, rs2_rdy;
   cdb_bfm             cdb;
   logic               grant;
   logic               issue_req;
   int_fifo_data       exec_data;
   logic               full;
   logic [2:0]         count;

   int_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .i_disp_valid       (disp_valid),
      .i_disp_data        (disp_data),
      .i_rs1_tag          (rs1_tag),
      .i_rs2_tag          (rs2_tag),
      .i_rs1_rdy          (rs1_rdy),
      .i_rs2_rdy          (rs2_rdy),
      .i_cdb              (cdb),
      .issue_granted      (grant),
      .o_issue_req        (issue_req),
      .int_exec_fifo_data (exec_data),
      .o_full             (full),
      .o_count            (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int_fifo_data d;
      int           t1, t2;
      bit           r1, r2;
   } m_ent_t;

   m_ent_t q[$];
   int     n_cmp = 0;
   int     n_err = 0;
   bit     cmp_en = 1'b0;

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic m_ent_t wake(m_ent_t e);
      m_ent_t r = e;
      if (cdb.cdb_valid) begin
         if (!r.r1 && r.t1 == int'(cdb.cdb_tag)) begin r.r1 = 1; r.d.rs1_data = cdb.cdb_result; end
         if (!r.r2 && r.t2 == int'(cdb.cdb_tag)) begin r.r2 = 1; r.d.rs2_data = cdb.cdb_result; end
      end
      return r;
   endfunction

   // Apply the currently driven inputs to the model as the next clock edge will.
   task automatic model_step();
      int     sel = -1;
      bit     was_full = (q.size() == DEPTH);
      m_ent_t ne;
      foreach (q[i]) if (sel < 0 && q[i].r1 && q[i].r2) sel = i;
`ifdef INT_IQ_FLUSH_EN
      if (cdb.cdb_branch && cdb.cdb_branch_taken) begin
         q.delete();
         return;
      end
`endif
      foreach (q[i]) q[i] = wake(q[i]);
      if (grant && sel >= 0) q.delete(sel);
      if (disp_valid && !was_full) begin
         ne.d = disp_data; ne.t1 = int'(rs1_tag); ne.t2 = int'(rs2_tag);
         ne.r1 = rs1_rdy; ne.r2 = rs2_rdy;
         q.push_back(wake(ne));
      end
   endtask

   task automatic compare_model();
      int_fifo_data exp_d = '0;
      bit           exp_req = 0;
      foreach (q[i]) if (!exp_req && q[i].r1 && q[i].r2) begin exp_req = 1; exp_d = q[i].d; end
      chk("issue_req", 128'(issue_req), 128'(exp_req));
      chk("exec_data", 128'(exec_data), 128'(exp_d));
      chk("full", 128'(full), 128'(q.size() == DEPTH));
      chk("count", 128'(count), 128'(q.size()));
   endtask

   always @(negedge clk) if (cmp_en && rst_n) compare_model();

   task automatic wait_cycle();
      @(negedge clk);
      #1;
   endtask

   task automatic set_idle();
      disp_valid = 0; disp_data = '0; rs1_tag = '0; rs2_tag = '0; rs1_rdy = 0; rs2_rdy = 0;
      cdb = '0; grant = 0;
   endtask

   function automatic int_fifo_data mk(logic [6:0] op, logic [31:0] a, logic [31:0] b);
      int_fifo_data d = '0;
      d.opcode = op; d.wb_valid = 1'b1; d.rs1_data = a; d.rs2_data = b;
      return d;
   endfunction

   task automatic disp(int_fifo_data d, int t1, bit r1, int t2, bit r2, bit g);
      set_idle();
      disp_valid = 1; disp_data = d;
      rs1_tag = TAG_W'(t1); rs1_rdy = r1; rs2_tag = TAG_W'(t2); rs2_rdy = r2; grant = g;
   endtask

   task automatic bcast(int tag, logic [31:0] res);
      cdb.cdb_valid = 1; cdb.cdb_tag = CDB_TAG_W'(tag); cdb.cdb_result = res;
   endtask

   task automatic drain();
      for (int i = 0; i < 8; i++) begin
         set_idle(); grant = 1; model_step(); wait_cycle();
      end
      set_idle();
   endtask

   task automatic rand_inputs();
      logic [6:0] ops [3];
      ops[0] = OP_TYPE; ops[1] = 7'b0010011; ops[2] = BRANCH_TYPE;
      disp_valid = ($urandom_range(99) < 60);
      disp_data  = mk(ops[$urandom_range(2)], $urandom, $urandom);
      disp_data.func3 = 3'($urandom); disp_data.rd_tag = CDB_TAG_W'($urandom);
      rs1_tag = TAG_W'($urandom_range(7)); rs2_tag = TAG_W'($urandom_range(7));
      rs1_rdy = $urandom_range(1); rs2_rdy = $urandom_range(1);
      cdb = '0;
      cdb.cdb_valid = $urandom_range(1);
      cdb.cdb_tag = CDB_TAG_W'($urandom_range(7));
      cdb.cdb_result = $urandom;
      cdb.cdb_branch = ($urandom_range(99) < 4);
      cdb.cdb_branch_taken = $urandom_range(1);
      grant = ($urandom_range(99) < 55);
   endtask

   initial begin
      set_idle();
      #12;
      chk("rst_issue_req", 128'(issue_req), 128'(0));
      chk("rst_full", 128'(full), 128'(0));
      chk("rst_count", 128'(count), 128'(0));
      chk("rst_data", 128'(exec_data), 128'(0));
      @(negedge clk);
      rst_n = 1;
      cmp_en = 1;
      #1;

      // ADD 5 + 7 with grant held high
      disp(mk(OP_TYPE, 32'd5, 32'd7), 0, 1, 0, 1, 1); model_step(); wait_cycle();
      chk("add_req", 128'(issue_req), 128'(1));
      chk("add_rs1", 128'(exec_data.rs1_data), 128'(5));
      chk("add_rs2", 128'(exec_data.rs2_data), 128'(7));
      set_idle(); grant = 1; model_step(); wait_cycle();
      chk("add_count", 128'(count), 128'(0));

      // Wakeup on tag 3
      disp(mk(OP_TYPE, 32'hdead, 32'd1), 3, 0, 0, 1, 0); model_step(); wait_cycle();
      chk("wk_req_before", 128'(issue_req), 128'(0));
      set_idle(); bcast(3, 32'h10); model_step(); wait_cycle();
      chk("wk_req_after", 128'(issue_req), 128'(1));
      chk("wk_rs1", 128'(exec_data.rs1_data), 128'(32'h10));
      drain();

      // Fill, then a fifth dispatch with grant
      for (int i = 1; i <= 4; i++) begin
         disp(mk(OP_TYPE, i, 0), 0, 1, 0, 1, 0); model_step(); wait_cycle();
      end
      chk("fill_full", 128'(full), 128'(1));
      disp(mk(OP_TYPE, 5, 0), 0, 1, 0, 1, 1); model_step(); wait_cycle();
      chk("fifth_count", 128'(count), 128'(3));
      for (int i = 2; i <= 4; i++) begin
         chk("order_head", 128'(exec_data.rs1_data), 128'(i));
         set_idle(); grant = 1; model_step(); wait_cycle();
      end
      chk("order_empty", 128'(count), 128'(0));

      // Younger ready entry bypasses an older waiting one
      disp(mk(OP_TYPE, 32'hA, 0), 2, 0, 0, 1, 0); model_step(); wait_cycle();
      disp(mk(BRANCH_TYPE, 32'hB, 0), 0, 1, 0, 1, 0); model_step(); wait_cycle();
      chk("ooo_first", 128'(exec_data.rs1_data), 128'(32'hB));
      set_idle(); grant = 1; bcast(2, 32'h22); model_step(); wait_cycle();
      chk("ooo_count", 128'(count), 128'(1));
      chk("ooo_second", 128'(exec_data.rs1_data), 128'(32'h22));
      drain();

      // Dispatch-time wakeup
      disp(mk(OP_TYPE, 0, 3), 4, 0, 0, 1, 0); bcast(4, 32'd9); model_step(); wait_cycle();
      chk("dw_req", 128'(issue_req), 128'(1));
      chk("dw_rs1", 128'(exec_data.rs1_data), 128'(9));
      drain();

      // Taken-branch broadcast with three entries plus a dispatch
      for (int i = 0; i < 3; i++) begin
         disp(mk(OP_TYPE, i, 0), 1, 0, 0, 1, 0); model_step(); wait_cycle();
      end
      disp(mk(OP_TYPE, 7, 0), 0, 1, 0, 1, 0);
      cdb.cdb_branch = 1; cdb.cdb_branch_taken = 1; model_step(); wait_cycle();
`ifdef INT_IQ_FLUSH_EN
      chk("flush_count", 128'(count), 128'(0));
      chk("flush_req", 128'(issue_req), 128'(0));
`else
      chk("nofl_count", 128'(count), 128'(4));
      chk("nofl_req", 128'(issue_req), 128'(1));
`endif
      drain();

      // Random traffic with a reset in the middle
      for (int k = 0; k < 3000; k++) begin
         rand_inputs();
         if (k == 1500) begin
            disp_valid = 1; grant = 1;
            #2 rst_n = 0;
            #1;
            chk("mid_rst_req", 128'(issue_req), 128'(0));
            chk("mid_rst_count", 128'(count), 128'(0));
            chk("mid_rst_data", 128'(exec_data), 128'(0));
            q.delete();
            wait_cycle();
            rst_n = 1;
            set_idle(); model_step();
         end else begin
            model_step();
         end
         wait_cycle();
      end
      set_idle();
      wait_cycle();
      cmp_en = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
